// File: rtl/add_test_sequencer_if.sv
// add_test_sequencer_if: run control plus RAM address/enable bundle of the add test sequencer.
interface add_test_sequencer_if #(parameter int ADDR_WIDTH = 8);
    logic                  start;
    logic [ADDR_WIDTH:0]   num_tests;
    logic                  pll_lock;
    logic                  r_en;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  we;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  busy;
    logic                  done;
    logic                  error;
    logic [31:0]           cycle_count;
    modport master (output start, num_tests, pll_lock,
                    input r_en, r_addr, we, w_addr, busy, done, error, cycle_count);
    modport slave (input start, num_tests, pll_lock,
                   output r_en, r_addr, we, w_addr, busy, done, error, cycle_count);
endinterface

// File: rtl/add_test_sequencer.sv
// add_test_sequencer: issues A/B read addresses one per clock and mirrors them to the C write
// port LATENCY cycles later, tracking run progress, completion and errors.
module add_test_sequencer #(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 6
) (
    input logic pll_clock,
    input logic reset,
    add_test_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    state_t                               state_q, state_d;
    logic [ADDR_WIDTH:0]                  num_q, num_d;
    logic                                 r_en_q, r_en_d;
    logic [ADDR_WIDTH-1:0]                r_addr_q, r_addr_d;
    logic [LATENCY-1:0]                   pv_q, pv_d;
    logic [LATENCY-1:0][ADDR_WIDTH-1:0]   pa_q, pa_d;
    logic                                 busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic [31:0]                          cc_q, cc_d;
    logic idle_like, active, num_ok, accept, reject, abort, last_addr, drained;
    assign idle_like = state_q == IDLE || state_q == DONE;
    assign active    = state_q == ISSUE || state_q == DRAIN;
    assign num_ok    = bus.num_tests != '0 &&
                       (!bus.num_tests[ADDR_WIDTH] || bus.num_tests[ADDR_WIDTH-1:0] == '0);
    assign accept    = idle_like && bus.start && bus.pll_lock && num_ok;
    assign reject    = idle_like && bus.start && !accept;
    assign abort     = active && !bus.pll_lock;
    assign last_addr = {1'b0, r_addr_q} == num_q - 1'b1;
    // cycle_count reads k-1 in the k-th busy cycle, so it doubles as the drain timer
    assign drained   = cc_q == 32'(num_q) + 32'(LATENCY - 1);
    always_ff @(posedge pll_clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            num_q    <= '0;
            r_en_q   <= 1'b0;
            r_addr_q <= '0;
            pv_q     <= '0;
            pa_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            cc_q     <= '0;
        end else begin
            state_q  <= state_d;
            num_q    <= num_d;
            r_en_q   <= r_en_d;
            r_addr_q <= r_addr_d;
            pv_q     <= pv_d;
            pa_q     <= pa_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
            cc_q     <= cc_d;
        end
    end
    always_comb begin
        state_d = accept                         ? ISSUE :
                  (reject || abort)              ? IDLE  :
                  (state_q == ISSUE && last_addr) ? DRAIN :
                  (state_q == DRAIN && drained)   ? DONE  : state_q;
    end
    always_comb begin
        num_d    = accept ? bus.num_tests : num_q;
        r_en_d   = state_d == ISSUE;
        r_addr_d = accept ? '0 : (state_q == ISSUE && state_d == ISSUE) ? r_addr_q + 1'b1 : r_addr_q;
        pv_d[0]  = r_en_q && !abort;
        pa_d[0]  = r_addr_q;
        for (int i = 1; i < LATENCY; i++) begin
            pv_d[i] = pv_q[i-1] && !abort;
            pa_d[i] = pa_q[i-1];
        end
        busy_d   = state_d == ISSUE || state_d == DRAIN;
        done_d   = state_d == DONE;
        error_d  = (reject || abort) ? 1'b1 : accept ? 1'b0 : error_q;
        cc_d     = accept ? '0 : (active && !abort) ? cc_q + 1 : cc_q;
    end
    assign bus.r_en        = r_en_q;
    assign bus.r_addr      = r_addr_q;
    assign bus.we          = pv_q[LATENCY-1];
    assign bus.w_addr      = pa_q[LATENCY-1];
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.error       = error_q;
    assign bus.cycle_count = cc_q;
endmodule

// File: tb/tb_add_test_sequencer.sv
// tb_add_test_sequencer: directed runs with a scoreboard of expected read/write addresses and cycles.
module tb_add_test_sequencer;
    localparam int AW = 8;
    localparam int L  = 6;
    typedef struct {int addr; int cyc;} exp_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int tests = 0, fails = 0;
    int cyc = 0, rd_cnt = 0, we_cnt = 0, busy_cnt = 0, last_ra = -1;
    int c0, rd0, we0, b0;
    exp_t rq[$], wq[$];
    add_test_sequencer_if #(.ADDR_WIDTH(AW)) bus();
    add_test_sequencer #(.ADDR_WIDTH(AW), .LATENCY(L)) dut (.pll_clock(clk), .reset(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic check(string tag, longint obs, longint exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (bus.busy === 1'b1) busy_cnt++;
        if (bus.r_en === 1'b1) begin
            rd_cnt++;
            last_ra = int'(bus.r_addr);
            if (rq.size() == 0) check("rd_unexpected", 1, 0);
            else begin
                e = rq.pop_front();
                check("rd_addr", bus.r_addr, e.addr);
                check("rd_cycle", cyc, e.cyc);
            end
        end
        if (bus.we === 1'b1) begin
            we_cnt++;
            if (wq.size() == 0) check("we_unexpected", 1, 0);
            else begin
                e = wq.pop_front();
                check("we_addr", bus.w_addr, e.addr);
                check("we_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic launch(int n);
        c0 = cyc; rd0 = rd_cnt; we0 = we_cnt; b0 = busy_cnt;
        for (int i = 0; i < n; i++) begin
            rq.push_back('{addr: i, cyc: c0 + 1 + i});
            wq.push_back('{addr: i, cyc: c0 + 1 + i + L});
        end
        bus.num_tests = (AW + 1)'(n);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("start_done_clr", bus.done, 0);
        check("start_err_clr", bus.error, 0);
        check("start_busy", bus.busy, 1);
    endtask

    task automatic finish_run(int n);
        int k = 0;
        while (bus.done !== 1'b1 && k < n + L + 20) begin
            tick();
            k++;
        end
        check("done_cycle", cyc - c0, n + L + 1);
        check("cycle_count", bus.cycle_count, n + L);
        check("busy_cycles", busy_cnt - b0, n + L);
        check("rd_pulses", rd_cnt - rd0, n);
        check("we_pulses", we_cnt - we0, n);
        check("rq_left", rq.size(), 0);
        check("wq_left", wq.size(), 0);
        check("done_busy", bus.busy, 0);
    endtask

    task automatic reject(int n, logic lock);
        rd0 = rd_cnt;
        bus.num_tests = (AW + 1)'(n);
        bus.pll_lock = lock;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.pll_lock = 1'b1;
        tick();
        check("rej_error", bus.error, 1);
        check("rej_done", bus.done, 0);
        check("rej_busy", bus.busy, 0);
        check("rej_no_rd", rd_cnt - rd0, 0);
    endtask

    initial begin
        int cc_hold;
        bus.start = 1'b0;
        bus.num_tests = '0;
        bus.pll_lock = 1'b1;
        #1 rst = 1'b1;
        #1;
        check("rst_r_en", bus.r_en, 0);
        check("rst_we", bus.we, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_error", bus.error, 0);
        check("rst_cc", bus.cycle_count, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        launch(4);
        finish_run(4);
        reject(0, 1'b1);
        launch(256);
        finish_run(256);
        check("last_raddr", last_ra, 255);
        reject(257, 1'b1);
        launch(5);
        tick();
        bus.num_tests = '0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("busy_start_err", bus.error, 0);
        finish_run(5);
        launch(3);
        finish_run(3);
        reject(4, 1'b0);
        launch(10);
        tick();
        tick();
        bus.pll_lock = 1'b0;
        rq.delete();
        wq.delete();
        we0 = we_cnt;
        tick();
        bus.pll_lock = 1'b1;
        check("abort_r_en", bus.r_en, 0);
        check("abort_error", bus.error, 1);
        check("abort_done", bus.done, 0);
        check("abort_busy", bus.busy, 0);
        cc_hold = int'(bus.cycle_count);
        repeat (L + 3) tick();
        check("abort_cc_hold", bus.cycle_count, cc_hold);
        check("abort_no_we", we_cnt - we0, 0);
        launch(4);
        repeat (5) tick();
        rst = 1'b1;
        #1;
        rq.delete();
        wq.delete();
        we0 = we_cnt;
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_we", bus.we, 0);
        check("mid_rst_cc", bus.cycle_count, 0);
        check("mid_rst_done", bus.done, 0);
        tick();
        tick();
        rst = 1'b0;
        repeat (L + 6) tick();
        check("post_rst_no_we", we_cnt - we0, 0);
        check("post_rst_busy", bus.busy, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/add_test_sequencer.md
Name: add_test_sequencer

Overview:
Run sequencer that sits directly upstream of the adder test datapath. It issues one read address per clock to the operand RAMs (A/B), and mirrors each address to the result RAM (C) write port exactly LATENCY cycles later. It tracks run progress and reports completion and errors to the Avalon-facing test control unit. The block runs on the single full-rate PLL clock and replaces the split pos/neg address generation.

Parameters:
ADDR_WIDTH, 8, width of RAM word addresses; the RAM depth is 2^ADDR_WIDTH.
LATENCY, 6, cycles from a registered read address to the matching result being presented at the C RAM write port; legal range 1..63.

Ports:
pll_clock  in  1  sole clock; all state updates on its rising edge.
reset  in  1  asynchronous, active-high reset.
start  in  1  run request; sampled only in IDLE or DONE.
num_tests  in  ADDR_WIDTH+1  number of operand pairs to run; legal range 1..2^ADDR_WIDTH.
pll_lock  in  1  PLL locked indicator; must be high to start a run and to keep it running.
r_en  out  1  read address valid.
r_addr  out  ADDR_WIDTH  read address for the A/B RAMs.
we  out  1  write enable for the C RAM.
w_addr  out  ADDR_WIDTH  write address for the C RAM.
busy  out  1  high in ISSUE and DRAIN.
done  out  1  sticky completion flag; cleared by the next accepted start.
error  out  1  sticky error flag; cleared by the next accepted start.
cycle_count  out  32  number of cycles spent in ISSUE plus DRAIN for the last run.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE.
  - All outputs are 0.
  - The delay pipeline is cleared (all valid bits 0).
- States: IDLE, ISSUE, DRAIN, DONE. All outputs are registered.
- IDLE/DONE, start=1:
  - Accepted when pll_lock=1 and 1<=num_tests<=2^ADDR_WIDTH. Then num_tests is latched, done=0, error=0, cycle_count=0, and the next state is ISSUE.
  - On the first ISSUE cycle, r_en=1 and r_addr=0.
  - If the request is not accepted, error=1, done=0, and the state goes to / stays in IDLE.
- ISSUE:
  - r_en=1 each cycle; r_addr increments by 1 per cycle (0,1,…,N-1).
  - After the cycle that presents N-1: r_en=0 and the next state is DRAIN.
  - When N=2^ADDR_WIDTH, r_addr reaches its all-ones value and does not wrap during the run.
- Write mirror:
  - A LATENCY-deep shift pipeline carries (r_en, r_addr).
  - we/w_addr equal r_en/r_addr delayed by exactly LATENCY cycles, so each address i produces exactly one we pulse with w_addr=i.
- DRAIN:
  - Lasts exactly LATENCY cycles; then the next state is DONE and done=1.
  - Timeline, with cycle 1 being the first r_en: the last we is at cycle N+LATENCY, and done rises at cycle N+LATENCY+1.
- cycle_count:
  - Increments once per cycle in ISSUE or DRAIN and holds in IDLE/DONE.
  - Final value is N+LATENCY.
- busy = (state==ISSUE || state==DRAIN).
- start while busy: ignored, with no effect on any output.
- pll_lock falls while busy:
  - Abort in that cycle: next state IDLE, r_en=0, and all pipeline valid bits are cleared, so we=0 from the next cycle onward.
  - error=1 and done=0; cycle_count holds its value.
- start in DONE: identical to IDLE; a new run begins immediately with no dead cycle beyond the registered transition.
- reset asserted mid-run: immediate return to the reset state; no we pulse after reset asserts.

Test Plan:
- Reset, then start with num_tests=4, LATENCY=6:
  - r_addr 0,1,2,3 with r_en on cycles 1–4.
  - we with w_addr 0,1,2,3 on cycles 7–10.
  - done=1 at cycle 11; cycle_count=10; busy high for cycles 1–10.
- num_tests=256, ADDR_WIDTH=8:
  - Exactly 256 r_en pulses, last r_addr=255, no wrap.
  - Exactly 256 we pulses; cycle_count=262.
- Illegal starts:
  - num_tests=0 → error=1, stays IDLE, no r_en.
  - num_tests=257 → error=1.
  - start with pll_lock=0 → error=1.
- Drop pll_lock at cycle 3 of a 10-test run:
  - r_en=0 next cycle, we never asserts afterwards, error=1, done=0, state IDLE.
- start pulse during ISSUE of a 5-test run is ignored (exactly 5 writes, cycle_count=11); then a start in DONE clears done/error and runs again with r_addr restarting at 0.
- Assert reset during DRAIN: all outputs go to 0 asynchronously, and no pending we appears after reset is released.
